leglite_mc_control: RTL and testbench
=====================================

// Module: leglite_mc_control
// PURPOSE
//  Multi-cycle control FSM for LEGLite; replaces the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with instr/data memory.
//  Drives the existing datapath control signals plus PC/IR enables.
//  Adds memory wait states, a wait timeout, unconditional branch B and an instruction-retire strobe.
// PARAMETERS
//  OPW      4   opcode width (opcodes below fit in 4 bits; upper bits must be 0 when OPW>4)
//  WAIT_MAX 15  max cycles waiting for imem_ready/dmem_ready before abort (1..255)
// PORTS
//  clock         in   1    single clock, rising edge
//  reset         in   1    asynchronous, active-high
//  opcode        in   OPW  opcode field from instruction register output
//  zero          in   1    ALU zero flag (CBZ)
//  imem_ready    in   1    instruction memory data valid
//  dmem_ready    in   1    data memory read data valid / write accepted
//  imem_req      out  1    instruction fetch request
//  ir_write      out  1    load instruction register
//  pc_write      out  1    update PC
//  pc_src        out  1    0: PC+4, 1: branch target
//  reg2loc       out  1    as single-cycle decoder
//  uncondbranch  out  1    as single-cycle decoder
//  branch        out  1    as single-cycle decoder
//  memread       out  1    data memory read request
//  memwrite      out  1    data memory write request
//  memtoreg      out  1    write-back source select
//  alu_select    out  3    0 ADD, 2 pass-B, 4 AND
//  alusrc        out  1    0 register, 1 immediate
//  regwrite      out  1    register file write enable
//  instr_done    out  1    1-cycle pulse when an instruction retires
//  bus_err       out  1    1-cycle pulse on memory wait timeout
//  halted        out  1    high in HALT state
// BEHAVIOUR
//  Opcodes: 0 ADD, 5 LD, 6 ST, 7 CBZ, 8 ADDI, 9 ANDI, 10 B; all others illegal.
//  Outputs combinational from state_q and op_q; while reset=1 every output is 0.
//  Reset: state_q=FETCH, op_q=0, wait_cnt=0.
//  FETCH: imem_req=1. On imem_ready: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//  DECODE: op_q <= opcode. Legal -> EXEC; illegal -> see CONFIGURATION.
//  EXEC: alu_select/alusrc/reg2loc per op (ADD 0/0/0, ADDI 0/1/0, ANDI 4/1/0, LD 0/1/0, ST 0/1/1, CBZ 2/0/1).
//   ADD/ADDI/ANDI -> WB. LD/ST -> MEM.
//   CBZ: branch=1; if zero, pc_write=1, pc_src=1. Then retire, -> FETCH.
//   B: uncondbranch=1, pc_write=1, pc_src=1. Retire, -> FETCH.
//  MEM: LD holds memread=1, memtoreg=1; ST holds memwrite=1, reg2loc=1; EXEC ALU controls held.
//   On dmem_ready: LD -> WB; ST retires, -> FETCH.
//  WB: regwrite=1, memtoreg=1 for LD else 0, ALU controls held. Retire, -> FETCH.
//  Retire: instr_done=1 in the final cycle of the instruction, coincident with the transition to FETCH.
//  Cycles: ALU op 4, LD 5, ST 4, CBZ/B 3 (zero-wait memory).
//  Timeout: wait_cnt clears on entering FETCH/MEM and counts each cycle without ready.
//   If wait_cnt==WAIT_MAX and ready=0: bus_err=1, -> FETCH, no pc_write/regwrite, no retire.
//   Ready arriving in the limit cycle wins; there is no timeout.
//   A FETCH timeout retries the same PC.
//  Reset mid-instruction aborts immediately; no partial write-back.
//  HALT: all controls 0, halted=1; exit only via reset.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE -> HALT, halted=1 (sticky until reset).
//  ILLEGAL_TRAP_EN undefined: the illegal opcode is a NOP. DECODE -> FETCH with instr_done=1.
//   halted is tied to 0 and the HALT state is unreachable.
// TESTING
//  ADD, op 0, zero-wait readies -> instr_done at cycle 4; regwrite=1 only in WB; alu_select=0.
//  LD, op 5, dmem_ready after 3 cycles -> memread held 3 cycles, then WB with memtoreg=1, regwrite=1.
//  CBZ, op 7: zero=1 -> pc_write=1, pc_src=1 in EXEC; zero=0 -> pc_write=0 in EXEC; both retire at cycle 3.
//  imem_ready held 0, WAIT_MAX=15 -> bus_err pulse after 16 FETCH cycles, back to FETCH, no ir_write.
//  Op 12 -> with ILLEGAL_TRAP_EN: halted=1 and stays there, imem_req=0; without: NOP retire, next fetch.
//  reset asserted during MEM of ST -> all outputs 0 asynchronously; after release, FETCH with imem_req=1.

Source files
------------

// File: rtl/leglite_mc_control_if.sv
// Handshake and control bundle between the LEGLite datapath/memories and the
// multi-cycle controller. The controller uses the slave modport, the datapath side uses master.
interface leglite_mc_control_if #(
  parameter int unsigned OPW = 4
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           imem_ready;
  logic           dmem_ready;
  logic           imem_req;
  logic           ir_write;
  logic           pc_write;
  logic           pc_src;
  logic           reg2loc;
  logic           uncondbranch;
  logic           branch;
  logic           memread;
  logic           memwrite;
  logic           memtoreg;
  logic [2:0]     alu_select;
  logic           alusrc;
  logic           regwrite;
  logic           instr_done;
  logic           bus_err;
  logic           halted;

  modport master (
    output opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, reg2loc, uncondbranch, branch,
           memread, memwrite, memtoreg, alu_select, alusrc, regwrite,
           instr_done, bus_err, halted
  );

  modport slave (
    input  opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, reg2loc, uncondbranch, branch,
           memread, memwrite, memtoreg, alu_select, alusrc, regwrite,
           instr_done, bus_err, halted
  );
endinterface

// File: rtl/leglite_mc_control.sv
// LEGLite multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait timeout.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes into a sticky HALT state; otherwise they retire as NOPs.
module leglite_mc_control #(
    parameter int unsigned OPW      = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input logic                 clock,
    input logic                 reset,
    leglite_mc_control_if.slave bus
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_LD   = OPW'(5);
    localparam logic [OPW-1:0] OP_ST   = OPW'(6);
    localparam logic [OPW-1:0] OP_CBZ  = OPW'(7);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(8);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(9);
    localparam logic [OPW-1:0] OP_B    = OPW'(10);
    localparam logic [7:0]     WAIT_LIM = 8'(WAIT_MAX);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;

    logic       imem_req_c, ir_write_c, pc_write_c, pc_src_c, reg2loc_c, ubr_c, branch_c;
    logic       memread_c, memwrite_c, memtoreg_c, alusrc_c, regwrite_c;
    logic       done_c, bus_err_c, halted_c;
    logic [2:0] alu_c;
    logic [2:0] op_alu;
    logic       op_alusrc, op_reg2loc;

    function automatic logic is_legal(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_LD, OP_ST, OP_CBZ, OP_ADDI, OP_ANDI, OP_B: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ALU controls chosen in EXEC stay held through MEM and WB.
    always_comb begin
        op_alu     = 3'd0;
        op_alusrc  = 1'b0;
        op_reg2loc = 1'b0;
        case (op_q)
            OP_ADDI, OP_LD: op_alusrc = 1'b1;
            OP_ANDI: begin op_alu = 3'd4; op_alusrc = 1'b1; end
            OP_ST:   begin op_alusrc = 1'b1; op_reg2loc = 1'b1; end
            OP_CBZ:  begin op_alu = 3'd2; op_reg2loc = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_cnt_d = '0;
        imem_req_c = 1'b0; ir_write_c = 1'b0; pc_write_c = 1'b0; pc_src_c  = 1'b0;
        reg2loc_c  = 1'b0; ubr_c      = 1'b0; branch_c   = 1'b0; memread_c = 1'b0;
        memwrite_c = 1'b0; memtoreg_c = 1'b0; alusrc_c   = 1'b0; regwrite_c = 1'b0;
        done_c     = 1'b0; bus_err_c  = 1'b0; halted_c   = 1'b0; alu_c     = 3'd0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_cnt_q == WAIT_LIM) begin
                    bus_err_c = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                op_d = bus.opcode;
                if (is_legal(bus.opcode)) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    done_c  = 1'b1;
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_c     = op_alu;
                alusrc_c  = op_alusrc;
                reg2loc_c = op_reg2loc;
                case (op_q)
                    OP_ADD, OP_ADDI, OP_ANDI: state_d = S_WB;
                    OP_LD, OP_ST:             state_d = S_MEM;
                    OP_CBZ: begin
                        branch_c   = 1'b1;
                        pc_write_c = bus.zero;
                        pc_src_c   = bus.zero;
                        done_c     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_B: begin
                        ubr_c      = 1'b1;
                        pc_write_c = 1'b1;
                        pc_src_c   = 1'b1;
                        done_c     = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                alu_c     = op_alu;
                alusrc_c  = op_alusrc;
                reg2loc_c = op_reg2loc;
                if (op_q == OP_LD) begin
                    memread_c  = 1'b1;
                    memtoreg_c = 1'b1;
                end else begin
                    memwrite_c = 1'b1;
                end
                if (bus.dmem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_cnt_q == WAIT_LIM) begin
                    bus_err_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_WB: begin
                alu_c      = op_alu;
                alusrc_c   = op_alusrc;
                reg2loc_c  = op_reg2loc;
                regwrite_c = 1'b1;
                memtoreg_c = (op_q == OP_LD);
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                halted_c = 1'b1;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low for the whole time reset is asserted, not just at the edge.
    assign bus.imem_req     = imem_req_c & ~reset;
    assign bus.ir_write     = ir_write_c & ~reset;
    assign bus.pc_write     = pc_write_c & ~reset;
    assign bus.pc_src       = pc_src_c & ~reset;
    assign bus.reg2loc      = reg2loc_c & ~reset;
    assign bus.uncondbranch = ubr_c & ~reset;
    assign bus.branch       = branch_c & ~reset;
    assign bus.memread      = memread_c & ~reset;
    assign bus.memwrite     = memwrite_c & ~reset;
    assign bus.memtoreg     = memtoreg_c & ~reset;
    assign bus.alu_select   = reset ? 3'd0 : alu_c;
    assign bus.alusrc       = alusrc_c & ~reset;
    assign bus.regwrite     = regwrite_c & ~reset;
    assign bus.instr_done   = done_c & ~reset;
    assign bus.bus_err      = bus_err_c & ~reset;
    assign bus.halted       = halted_c & ~reset;

endmodule

// File: tb/tb_leglite_mc_control.sv
// Directed bench for leglite_mc_control: per-cycle control outputs for each instruction class,
// fetch timeout, illegal opcode handling (both builds) and asynchronous reset mid-instruction.
module tb_leglite_mc_control;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    leglite_mc_control_if #(.OPW(4)) bus ();

    leglite_mc_control #(.OPW(4), .WAIT_MAX(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FETCH with imem_ready, then DECODE; leaves the bench at the DECODE sample point.
    task automatic fetch_decode(input logic [3:0] op);
        @(negedge clock);
        bus.imem_ready = 1'b1;
        bus.opcode     = op;
        #1;
        check("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        check("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        check("fetch_pc_src", 32'(bus.pc_src), 32'd0);
        @(negedge clock);
        bus.imem_ready = 1'b0;
        #1;
        check("decode_imem_req", 32'(bus.imem_req), 32'd0);
        check("decode_ir_write", 32'(bus.ir_write), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode = '0; bus.zero = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        #1;
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_imem_req", 32'(bus.imem_req), 32'd1);

        // ADD: retire in WB, the 4th cycle
        fetch_decode(4'd0);
        @(negedge clock); #1;
        check("add_exec_alu", 32'(bus.alu_select), 32'd0);
        check("add_exec_alusrc", 32'(bus.alusrc), 32'd0);
        check("add_exec_regwrite", 32'(bus.regwrite), 32'd0);
        check("add_exec_done", 32'(bus.instr_done), 32'd0);
        @(negedge clock); #1;
        check("add_wb_regwrite", 32'(bus.regwrite), 32'd1);
        check("add_wb_memtoreg", 32'(bus.memtoreg), 32'd0);
        check("add_wb_done", 32'(bus.instr_done), 32'd1);

        // LD: dmem_ready on the 3rd MEM cycle
        fetch_decode(4'd5);
        @(negedge clock); #1;
        check("ld_exec_alusrc", 32'(bus.alusrc), 32'd1);
        check("ld_exec_memread", 32'(bus.memread), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.dmem_ready = (i == 2);
            #1;
            check("ld_mem_memread", 32'(bus.memread), 32'd1);
            check("ld_mem_memtoreg", 32'(bus.memtoreg), 32'd1);
            check("ld_mem_regwrite", 32'(bus.regwrite), 32'd0);
            check("ld_mem_done", 32'(bus.instr_done), 32'd0);
        end
        @(negedge clock);
        bus.dmem_ready = 1'b0;
        #1;
        check("ld_wb_regwrite", 32'(bus.regwrite), 32'd1);
        check("ld_wb_memtoreg", 32'(bus.memtoreg), 32'd1);
        check("ld_wb_memread", 32'(bus.memread), 32'd0);
        check("ld_wb_done", 32'(bus.instr_done), 32'd1);

        // CBZ taken then not taken
        for (int z = 1; z >= 0; z--) begin
            fetch_decode(4'd7);
            @(negedge clock);
            bus.zero = z[0];
            #1;
            check("cbz_branch", 32'(bus.branch), 32'd1);
            check("cbz_pc_write", 32'(bus.pc_write), 32'(z));
            check("cbz_pc_src", 32'(bus.pc_src), 32'(z));
            check("cbz_alu", 32'(bus.alu_select), 32'd2);
            check("cbz_reg2loc", 32'(bus.reg2loc), 32'd1);
            check("cbz_done", 32'(bus.instr_done), 32'd1);
        end
        bus.zero = 1'b0;

        // B
        fetch_decode(4'd10);
        @(negedge clock); #1;
        check("b_uncond", 32'(bus.uncondbranch), 32'd1);
        check("b_pc_write", 32'(bus.pc_write), 32'd1);
        check("b_pc_src", 32'(bus.pc_src), 32'd1);
        check("b_done", 32'(bus.instr_done), 32'd1);
        @(negedge clock); #1;
        check("b_next_fetch", 32'(bus.imem_req), 32'd1);

        // ST, reset asserted mid-MEM
        fetch_decode(4'd6);
        @(negedge clock); #1;
        check("st_exec_reg2loc", 32'(bus.reg2loc), 32'd1);
        check("st_exec_alusrc", 32'(bus.alusrc), 32'd1);
        @(negedge clock); #1;
        check("st_mem_memwrite", 32'(bus.memwrite), 32'd1);
        check("st_mem_reg2loc", 32'(bus.reg2loc), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("st_rst_memwrite", 32'(bus.memwrite), 32'd0);
        check("st_rst_reg2loc", 32'(bus.reg2loc), 32'd0);
        check("st_rst_imem_req", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("st_rel_imem_req", 32'(bus.imem_req), 32'd1);
        check("st_rel_memwrite", 32'(bus.memwrite), 32'd0);

        // FETCH timeout: bus_err on the 16th waiting cycle, then fetch again
        for (int i = 0; i < 16; i++) begin
            check("to_bus_err", 32'(bus.bus_err), 32'(i == 15));
            check("to_ir_write", 32'(bus.ir_write), 32'd0);
            @(negedge clock); #1;
        end
        check("to_refetch", 32'(bus.imem_req), 32'd1);
        check("to_bus_err_clr", 32'(bus.bus_err), 32'd0);

        // Illegal opcode 12
        fetch_decode(4'd12);
`ifdef ILLEGAL_TRAP_EN
        check("ill_decode_done", 32'(bus.instr_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.imem_ready = 1'b1;
            #1;
            check("ill_halted", 32'(bus.halted), 32'd1);
            check("ill_imem_req", 32'(bus.imem_req), 32'd0);
        end
        bus.imem_ready = 1'b0;
`else
        check("ill_decode_done", 32'(bus.instr_done), 32'd1);
        check("ill_decode_halted", 32'(bus.halted), 32'd0);
        @(negedge clock); #1;
        check("ill_next_fetch", 32'(bus.imem_req), 32'd1);
        check("ill_halted", 32'(bus.halted), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
